// File: rtl/if_stage_hazard_if.sv
// Instruction-memory fetch handshake bundle for if_stage_hazard.
// The fetch stage is the master (issues req/addr); the memory is the slave
// (answers with ready/rdata in the same cycle it accepts a request).
interface if_stage_hazard_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage_hazard.sv
// Instruction-fetch stage with IF/ID pipeline register and load-use hazard
// detector. Owns the PC, handshakes with instruction memory, holds or flushes
// the fetched instruction and raises 'bubble' toward the ID/EX register when
// a load in EX feeds the instruction sitting in ID.
// Optional macro IF_PERF_EN adds saturating stall/flush cycle counters.
module if_stage_hazard #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_hazard_if.master imem,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        ex_MemToReg,
    input  logic [4:0]  ex_Rt_a,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
`ifdef IF_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        bubble
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        hazard;
    logic        req;
    logic [31:0] addr;
    logic [31:0] stale_addr;

    assign hazard = ifid_valid && ex_MemToReg && (ex_Rt_a != 5'd0) &&
                    ((ex_Rt_a == ifid_instr[25:21]) || (ex_Rt_a == ifid_instr[20:16]));
    assign bubble = hazard && !branch_taken;

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    // Advance the fetch FSM; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; a redirect with a request still
    // unanswered must wait out that stale response in DISCARD.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        addr       = pc;
        case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                req = !hazard;
                if (branch_taken && req && !imem.imem_ready) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                req  = 1'b1;
                addr = stale_addr;
                if (imem.imem_ready) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Remember the address whose response must be dropped after a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stale_addr <= 32'h0;
        end else if (state == FETCH && state_next == DISCARD) begin
            stale_addr <= pc;
        end
    end

    // PC and IF/ID register: redirect beats hazard stall beats normal fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            ifid_instr <= 32'h0;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            pc         <= branch_target;
            ifid_instr <= 32'h0;
            ifid_valid <= 1'b0;
        end else if (!hazard) begin
            case (state)
                FETCH: begin
                    if (imem.imem_ready) begin
                        ifid_instr <= imem.imem_rdata;
                        ifid_pc4   <= pc + STEP;
                        ifid_valid <= 1'b1;
                        pc         <= pc + STEP;
                    end else begin
                        ifid_instr <= 32'h0;
                        ifid_valid <= 1'b0;
                    end
                end
                DISCARD: begin
                    ifid_instr <= 32'h0;
                    ifid_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IF_PERF_EN
    // Saturating counts of stall cycles and redirect cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 32'h0;
            flush_cnt <= 32'h0;
        end else begin
            if (bubble && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch_taken && flush_cnt != 32'hFFFF_FFFF) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_hazard.sv
// Directed bench for if_stage_hazard: sequential fetch, load-use stall,
// $0 exemption, redirect into DISCARD, memory wait states, PC wrap and
// asynchronous reset in the middle of a wait.
module tb_if_stage_hazard;

    logic        clk;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ex_MemToReg;
    logic [4:0]  ex_Rt_a;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        bubble;
`ifdef IF_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_vec;
    int n_miss;

    if_stage_hazard_if bus ();

    // Memory model: word at 0x10 is a load reading r1/r2, elsewhere data = address.
    assign bus.imem_rdata = (bus.imem_addr == 32'h0000_0010) ? 32'h8C22_0000 : bus.imem_addr;

    if_stage_hazard dut (
        .clk           (clk),
        .reset         (reset),
        .imem          (bus),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ex_MemToReg   (ex_MemToReg),
        .ex_Rt_a       (ex_Rt_a),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
`ifdef IF_PERF_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .bubble        (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset          = 1'b0;
        bus.imem_ready = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        ex_MemToReg    = 1'b0;
        ex_Rt_a        = 5'd0;

        // Reset state
        @(negedge clk);
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_req", bus.imem_req, 1'b0);
        check_output("rst_valid", ifid_valid, 1'b0);
        check_output("rst_instr", ifid_instr, 32'h0);
        check_output("rst_pc4", ifid_pc4, 32'h0);

        // Release reset; BOOT keeps the request low for one cycle
        @(negedge clk);
        reset          = 1'b1;
        bus.imem_ready = 1'b1;
        #1;
        check_output("boot_req", bus.imem_req, 1'b0);
        tick();
        check_output("fetch0_req", bus.imem_req, 1'b1);
        check_output("fetch0_addr", bus.imem_addr, 32'h0);
        check_output("fetch0_valid", ifid_valid, 1'b0);

        // Back-to-back sequential fetches 0,4,8,12
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("seq_instr", ifid_instr, 32'(i * 4));
            check_output("seq_pc", pc, 32'((i + 1) * 4));
            check_output("seq_valid", ifid_valid, 1'b1);
        end
        tick();
        check_output("ld_instr", ifid_instr, 32'h8C22_0000);
        check_output("ld_pc4", ifid_pc4, 32'h14);

        // Load in EX writes r2, ID reads r2 as rt: one stall
        ex_MemToReg = 1'b1;
        ex_Rt_a     = 5'd2;
        #1;
        check_output("haz_bubble", bubble, 1'b1);
        check_output("haz_req", bus.imem_req, 1'b0);
        branch_taken = 1'b1;
        #1;
        check_output("haz_br_bubble", bubble, 1'b0);
        branch_taken = 1'b0;
        #1;
        tick();
        check_output("haz_pc_hold", pc, 32'h14);
        check_output("haz_instr_hold", ifid_instr, 32'h8C22_0000);

        // rs field match (r1) also stalls; $0 never does
        ex_Rt_a = 5'd1;
        #1;
        check_output("haz_rs_bubble", bubble, 1'b1);
        ex_Rt_a = 5'd0;
        #1;
        check_output("r0_bubble", bubble, 1'b0);
        check_output("r0_req", bus.imem_req, 1'b1);
        tick();
        check_output("r0_instr", ifid_instr, 32'h14);
        check_output("r0_pc", pc, 32'h18);
        ex_MemToReg = 1'b0;

        // Memory stalls, then redirect to 0x100 with request outstanding
        bus.imem_ready = 1'b0;
        tick();
        check_output("wait_valid", ifid_valid, 1'b0);
        check_output("wait_pc", pc, 32'h18);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        #1;
        check_output("disc_pc", pc, 32'h100);
        check_output("disc_valid", ifid_valid, 1'b0);
        check_output("disc_req", bus.imem_req, 1'b1);
        check_output("disc_addr", bus.imem_addr, 32'h18);
        bus.imem_ready = 1'b1;
        tick();
        check_output("drop_valid", ifid_valid, 1'b0);
        check_output("drop_instr", ifid_instr, 32'h0);
        check_output("redir_addr", bus.imem_addr, 32'h100);

        // Three wait cycles: address stable, NOPs into IF/ID
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("w3_addr", bus.imem_addr, 32'h100);
            check_output("w3_instr", ifid_instr, 32'h0);
            check_output("w3_pc", pc, 32'h100);
        end
        bus.imem_ready = 1'b1;
        tick();
        check_output("tgt_instr", ifid_instr, 32'h100);
        check_output("tgt_valid", ifid_valid, 1'b1);
        check_output("tgt_pc4", ifid_pc4, 32'h104);

        // Redirect with ready in the same cycle, then PC wraps at the top
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        check_output("brr_pc", pc, 32'hFFFF_FFFC);
        check_output("brr_valid", ifid_valid, 1'b0);
        tick();
        check_output("wrap_instr", ifid_instr, 32'hFFFF_FFFC);
        check_output("wrap_pc", pc, 32'h0);
        check_output("wrap_pc4", ifid_pc4, 32'h0);

        // Redirect to 0x40, wait, then reset mid-wait
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken   = 1'b0;
        bus.imem_ready = 1'b0;
        tick();
        check_output("pre_rst_pc", pc, 32'h40);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_rst_pc", pc, 32'h0);
        check_output("mid_rst_req", bus.imem_req, 1'b0);
        check_output("mid_rst_valid", ifid_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
